// File: rtl/param_power_alu.sv
// param_power_alu: handshaked ALU with accumulator; optional iterative mul/div when POWER_ALU_MULDIV_EN is defined.
// Ops 0-B finish in one cycle; ops C-F take WIDTH+1 cycles with muldiv, otherwise they return an error.
module param_power_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [2*WIDTH+4:0] opcode_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [WIDTH-1:0]   ans_out,
    output logic               carry_out,
    output logic               zero_out,
    output logic               err_out,
    output logic               valid_out,
    input  logic               ready_in
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_acc, r_ans;
    logic             r_carry, r_zero, r_err, r_valid;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_a, w_b, w_res;
    logic [WIDTH:0]   w_add, w_sub, w_shl;
    logic [5:0]       w_sh;
    logic             w_cy, w_er;
    assign w_op  = opcode_in[3:0];
    assign w_a   = opcode_in[2*WIDTH+4] ? r_acc : opcode_in[WIDTH+3:4];
    assign w_b   = opcode_in[2*WIDTH+3:WIDTH+4];
    assign w_sh  = 6'(32'(w_b) % 32'(WIDTH));
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} - {1'b0, w_b};
    // bit WIDTH of the widened shift is the last bit pushed out, 0 when shift is 0
    assign w_shl = {1'b0, w_a} << w_sh;
    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_er  = 1'b0;
        case (w_op)
            4'h0: {w_cy, w_res} = w_add;
            4'h1: {w_cy, w_res} = w_sub;
            4'h2: w_res = w_a & w_b;
            4'h3: w_res = w_a | w_b;
            4'h4: w_res = w_a ^ w_b;
            4'h5: w_res = ~w_a;
            4'h6: {w_cy, w_res} = w_shl;
            4'h7: w_res = w_a >> w_sh;
            4'h8: w_res = (w_a << w_sh) | (w_a >> (WIDTH - int'(w_sh)));
            4'h9: w_res = (w_a >> w_sh) | (w_a << (WIDTH - int'(w_sh)));
            4'hA: {w_cy, w_res} = {1'b0, w_a} + (WIDTH+1)'(1);
            4'hB: {w_cy, w_res} = {1'b0, w_a} - (WIDTH+1)'(1);
            default: w_er = 1'b1;
        endcase
    end
`ifdef POWER_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_b, r_hi, r_lo;
    logic [WIDTH-1:0] w_hi, w_lo, w_mres;
    logic [WIDTH:0]   w_madd, w_rsh, w_dsub;
    logic             w_ge;
    // hi:lo is the product register for multiply and remainder:quotient for divide
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
    assign w_dsub = w_rsh - {1'b0, r_b};
    assign w_ge   = !w_dsub[WIDTH];
    assign w_hi   = r_op[1] ? (w_ge ? w_dsub[WIDTH-1:0] : w_rsh[WIDTH-1:0]) : w_madd[WIDTH:1];
    assign w_lo   = r_op[1] ? {r_lo[WIDTH-2:0], w_ge} : {w_madd[0], r_lo[WIDTH-1:1]};
    assign w_mres = r_op[0] ? w_hi : w_lo;
`endif
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ans   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
`ifdef POWER_ALU_MULDIV_EN
            r_cnt   <= '0;
            r_op    <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (valid_in) begin
`ifdef POWER_ALU_MULDIV_EN
                    if (w_op[3:2] == 2'b11) begin
                        r_state <= EXEC;
                        r_cnt   <= '0;
                        r_op    <= w_op[1:0];
                        r_b     <= w_b;
                        r_hi    <= '0;
                        r_lo    <= w_a;
                    end else
`endif
                    begin
                        r_state <= DONE;
                        r_ans   <= w_res;
                        r_carry <= w_cy;
                        r_zero  <= (w_res == '0);
                        r_err   <= w_er;
                        r_valid <= 1'b1;
                        r_acc   <= w_res;
                    end
                end
`ifdef POWER_ALU_MULDIV_EN
                EXEC: begin
                    r_hi  <= w_hi;
                    r_lo  <= w_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_state <= DONE;
                        r_ans   <= w_mres;
                        r_carry <= 1'b0;
                        r_zero  <= (w_mres == '0);
                        r_err   <= r_op[1] && (r_b == '0);
                        r_valid <= 1'b1;
                        r_acc   <= w_mres;
                    end
                end
`endif
                DONE: if (ready_in) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign ready_out = (r_state == IDLE);
    assign ans_out   = r_ans;
    assign carry_out = r_carry;
    assign zero_out  = r_zero;
    assign err_out   = r_err;
    assign valid_out = r_valid;
endmodule

// File: doc/param_power_alu.md
PARAM_POWER_ALU -- requirements
Module: param_power_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous and active-high.
REQ-004 opcode_in  input  2*WIDTH+5  request word {acc, B[WIDTH-1:0], A[WIDTH-1:0], op[3:0]}, MSB = acc.
REQ-005 valid_in  input  1  request present on opcode_in.
REQ-006 ready_out  output  1  block can accept a request.
REQ-007 ans_out  output  WIDTH  result word.
REQ-008 carry_out  output  1  carry/borrow of result.
REQ-009 zero_out  output  1  ans_out == 0.
REQ-010 err_out  output  1  divide-by-zero or disabled op.
REQ-011 valid_out  output  1  ans_out/flags valid.
REQ-012 ready_in  input  1  consumer accepts result.

Function
REQ-013 FSM states IDLE, EXEC, DONE; ready_out SHALL be 1 only in IDLE.
REQ-014 Request accepted when valid_in && ready_out; opcode_in sampled only on that edge.
REQ-015 When acc = 1, operand A SHALL be replaced by the internal accumulator register; B always taken from opcode_in.
REQ-016 Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B mod WIDTH, 7 SHR logical, 8 ROL, 9 ROR, A INC A, B DEC A, C MUL low word, D MUL high word, E DIV quotient A/B, F MOD remainder.
REQ-017 Ops 0-B SHALL go IDLE->DONE; valid_out asserted the cycle after acceptance (latency 1).
REQ-018 Ops C-F SHALL go IDLE->EXEC, iterate exactly WIDTH cycles (shift-add multiply, restoring divide), then DONE; valid_out asserted WIDTH+1 cycles after acceptance.
REQ-019 carry_out: ADD carry-out, SUB borrow (A<B), INC carry when A all-ones, DEC borrow when A=0, SHL last bit shifted out (0 if shift amount 0); 0 for all other ops.
REQ-020 Divide by zero (E/F, B=0): quotient all-ones, remainder = A, err_out = 1, still WIDTH+1 latency.
REQ-021 In DONE, ans_out and flags SHALL hold stable while valid_out=1 and ready_in=0.
REQ-022 DONE with ready_in=1 SHALL return to IDLE next cycle; valid_out drops, ready_out rises same edge; no back-to-back acceptance in the DONE cycle.
REQ-023 Accumulator SHALL load ans_out on the edge entering DONE, including error results.
REQ-024 valid_in asserted while ready_out=0 SHALL be ignored with no state change.
REQ-025 In EXEC, opcode_in changes SHALL have no effect on the in-flight result.

Reset
REQ-026 rst_in=1 SHALL immediately force IDLE, ans_out=0, carry_out=0, zero_out=0, err_out=0, valid_out=0, accumulator=0, iteration counter=0.
REQ-027 Reset during EXEC or DONE SHALL abandon the operation with no result delivered; ready_out=1 on the first edge after release.

Configuration
REQ-028 Macro POWER_ALU_MULDIV_EN defined: ops C-F behave per REQ-018/020.
REQ-029 Macro undefined: no multiply/divide datapath; ops C-F take the latency-1 path, ans_out=0, carry_out=0, err_out=1; EXEC state unused.

Verification
REQ-030 WIDTH=8, acc=0, A=50, B=25, op 0 -> valid_out after 1 cycle, ans_out=75, carry_out=0, zero_out=0.
REQ-031 WIDTH=8, A=25, B=50, op 1 -> ans_out=231, carry_out=1; then acc=1, B=25, op 0 -> ans_out=0, carry_out=1, zero_out=1.
REQ-032 WIDTH=8, MULDIV_EN, A=50, B=25, op C -> ans_out=226 after 9 cycles; op D -> ans_out=4; op E -> 2; op F -> 0.
REQ-033 WIDTH=8, op E, A=50, B=0 -> ans_out=255, err_out=1; op F same -> ans_out=50, err_out=1.
REQ-034 Hold ready_in=0 5 cycles after result -> ans_out stable, ready_out=0, valid_in pulses ignored; ready_in=1 -> ready_out=1 next cycle.
REQ-035 Assert rst_in mid-EXEC of op C -> outputs zero immediately, accumulator 0, no valid_out; next ADD with acc=1, B=7 -> ans_out=7.
